// File: rtl/beta_pkg.sv
// beta_pkg
//   Shared constants for the Beta RF stage: injected instruction words,
//   opcode values, pcsel encodings and a small opcode-legality helper.
//   Instruction words are 32 bits; wider datapaths zero-extend them.

package beta_pkg;

  // Injected instructions
  // NOP = ADD(R31, R31, R31); BNE trap = BNE(R31, -1, XP)
  localparam logic [31:0] INSTR_NOP = 32'h83FF_FFFF;
  localparam logic [31:0] INSTR_BNE = 32'h7BDF_FFFF;

  // Opcodes that are special-cased in the RF stage
  localparam logic [5:0] OP_LD  = 6'b011000;
  localparam logic [5:0] OP_ST  = 6'b011001;
  localparam logic [5:0] OP_JMP = 6'b011011;
  localparam logic [5:0] OP_BEQ = 6'b011101;
  localparam logic [5:0] OP_BNE = 6'b011110;
  localparam logic [5:0] OP_LDR = 6'b011111;

  // pcsel encodings
  localparam logic [1:0] PCSEL_SEQ    = 2'd0;
  localparam logic [1:0] PCSEL_BRANCH = 2'd1;
  localparam logic [1:0] PCSEL_JMP    = 2'd2;
  localparam logic [1:0] PCSEL_ILLOP  = 2'd3;

  // irsrc encodings (2 and 3 both inject a NOP)
  localparam logic [1:0] IRSRC_FETCH = 2'd0;
  localparam logic [1:0] IRSRC_TRAP  = 2'd1;

  // R31 always reads as zero
  localparam logic [4:0] REG_ZERO = 5'd31;

  // Beta instruction fields; rb of register-form ops is lit[15:11]
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rc;
    logic [4:0]  ra;
    logic [15:0] lit;
  } instr_t;

  // ALU ops occupy 10xxxx (register form) and 11xxxx (constant form).
  // Within each group of eight, function code 3'b111 is unassigned.
  function automatic logic is_alu_op(input logic [5:0] op);
    logic legal;
    legal = 1'b0;
    if (op[5]) begin
      case (op[2:0])
        3'b000, 3'b001, 3'b010, 3'b011,
        3'b100, 3'b101, 3'b110: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_LDR: legal = 1'b1;
      default:                                      legal = is_alu_op(op);
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/beta_regfile.sv
// beta_regfile
//   32 x XLEN register file, two combinational read ports, one write port.
//   R31 reads as zero and writes to it are dropped. A read of the address
//   being written in the same cycle returns the write data (write-through).
//   Contents are not reset.
//
// Ports
//   clk       : clock
//   ra1, ra2  : read addresses
//   rd1, rd2  : read data (combinational)
//   wa, wd    : write address / data
//   werf      : write enable, captured on the rising edge of clk

module beta_regfile
  import beta_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic [4:0]      ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd2,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic            werf
);

  logic [XLEN-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (werf && (wa != REG_ZERO)) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    if (ra1 == REG_ZERO) begin
      rd1 = '0;
    end else if (werf && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = mem[ra1];
    end
  end

  always_comb begin
    if (ra2 == REG_ZERO) begin
      rd2 = '0;
    end else if (werf && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = mem[ra2];
    end
  end

endmodule

// File: rtl/beta_rf_bypass.sv
// beta_rf_bypass
//   Register-fetch stage of a pipelined Beta: pc/ir pipeline registers,
//   instruction decode, register-file read with bypass from NBYP downstream
//   stages, branch-target and pcsel generation, and an interlock that stalls
//   when a matching bypass source has not produced its data yet.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   stall_in            : downstream hold
//   irsrc               : 0 fetched instr, 1 BNE trap, 2/3 NOP
//   pcin, irin          : fetch-stage pc / instruction
//   wa, wd, werf        : register-file write port
//   byp_addr/data       : per-source destination register and value
//   byp_valid/ready     : source holds a write / value is available
//   pcout, irout        : RF-stage pc / instruction
//   a, b, d, jt         : operands for ALU, store data and jump target
//   cRelativeA          : pc + 4*sxt(literal)
//   pcsel, z            : next-pc select, operand1 == 0
//   stall_out           : interlock request to upstream
//   stall_cnt           : saturating count of interlock cycles

module beta_rf_bypass
  import beta_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NBYP = 3,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic [1:0]        irsrc,
  input  logic [XLEN-1:0]   pcin,
  input  logic [XLEN-1:0]   irin,
  input  logic [4:0]        wa,
  input  logic [XLEN-1:0]   wd,
  input  logic              werf,
  input  logic [NBYP*5-1:0] byp_addr,
  input  logic [NBYP*XLEN-1:0] byp_data,
  input  logic [NBYP-1:0]   byp_valid,
  input  logic [NBYP-1:0]   byp_ready,
  output logic [XLEN-1:0]   pcout,
  output logic [XLEN-1:0]   irout,
  output logic [XLEN-1:0]   a,
  output logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   d,
  output logic [XLEN-1:0]   jt,
  output logic [XLEN-1:0]   cRelativeA,
  output logic [1:0]        pcsel,
  output logic              z,
  output logic              stall_out,
  output logic [CNTW-1:0]   stall_cnt
);

  localparam logic [XLEN-1:0] NOP_WORD = XLEN'(INSTR_NOP);
  localparam logic [XLEN-1:0] BNE_WORD = XLEN'(INSTR_BNE);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ir_q;
  logic [CNTW-1:0] stall_cnt_q;

  instr_t          ins;
  logic            reg_form;
  logic [4:0]      ra1;
  logic [4:0]      ra2;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            op1_wait;
  logic            op2_wait;
  logic [XLEN-1:0] sxt;
  logic            flush;

  // ---------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------
  assign ins      = instr_t'(ir_q[31:0]);
  assign reg_form = (ins.opcode[5:4] == 2'b10);

  always_comb begin
    ra1 = (ins.opcode == OP_LDR) ? REG_ZERO : ins.ra;

    if (ins.opcode == OP_ST) begin
      ra2 = ins.rc;
    end else if (reg_form) begin
      ra2 = ins.lit[15:11];
    end else begin
      ra2 = REG_ZERO;
    end
  end

  // ---------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------
  beta_regfile #(
    .XLEN (XLEN)
  ) u_regfile (
    .clk  (clk),
    .ra1  (ra1),
    .rd1  (rf_rd1),
    .ra2  (ra2),
    .rd2  (rf_rd2),
    .wa   (wa),
    .wd   (wd),
    .werf (werf)
  );

  // ---------------------------------------------------------------
  // Bypass selection: walk from oldest to youngest so the youngest
  // matching source (lowest index) is the one left standing.
  // ---------------------------------------------------------------
  always_comb begin
    op1      = rf_rd1;
    op2      = rf_rd2;
    op1_wait = 1'b0;
    op2_wait = 1'b0;

    for (int i = NBYP - 1; i >= 0; i--) begin
      if (byp_valid[i] && (byp_addr[i*5 +: 5] == ra1) && (ra1 != REG_ZERO)) begin
        op1      = byp_data[i*XLEN +: XLEN];
        op1_wait = ~byp_ready[i];
      end
      if (byp_valid[i] && (byp_addr[i*5 +: 5] == ra2) && (ra2 != REG_ZERO)) begin
        op2      = byp_data[i*XLEN +: XLEN];
        op2_wait = ~byp_ready[i];
      end
    end
  end

  assign stall_out = op1_wait | op2_wait;

  // ---------------------------------------------------------------
  // Operand and branch outputs
  // ---------------------------------------------------------------
  assign sxt        = {{(XLEN-16){ins.lit[15]}}, ins.lit};
  assign cRelativeA = pc_q + (sxt << 2);

  assign a  = (ins.opcode == OP_LDR) ? cRelativeA : op1;
  assign b  = reg_form ? op2 : sxt;
  assign d  = op2;
  assign jt = op1;
  assign z  = (op1 == '0);

  always_comb begin
    pcsel = PCSEL_SEQ;
    if (!is_legal_op(ins.opcode)) begin
      pcsel = PCSEL_ILLOP;
    end else begin
      case (ins.opcode)
        OP_JMP:  pcsel = PCSEL_JMP;
        OP_BEQ:  pcsel = z ? PCSEL_BRANCH : PCSEL_SEQ;
        OP_BNE:  pcsel = z ? PCSEL_SEQ : PCSEL_BRANCH;
        default: pcsel = PCSEL_SEQ;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Pipeline registers. A flush (trap or NOP injection) wins over both
  // the downstream hold and our own interlock, so a stalled instruction
  // can always be squashed.
  // ---------------------------------------------------------------
  assign flush = (irsrc != IRSRC_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      ir_q <= NOP_WORD;
    end else if (flush) begin
      pc_q <= pcin;
      ir_q <= (irsrc == IRSRC_TRAP) ? BNE_WORD : NOP_WORD;
    end else if (!(stall_in || stall_out)) begin
      pc_q <= pcin;
      ir_q <= irin;
    end
  end

  // Interlock cycles only; cycles that are flushed are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_out && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNTW'(1);
    end
  end

  assign pcout     = pc_q;
  assign irout     = ir_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_beta_rf_bypass.sv
module tb_beta_rf_bypass;

  localparam int XLEN = 32;
  localparam int NBYP = 3;
  localparam int CNTW = 16;

  localparam logic [31:0] W_NOP = 32'h83FF_FFFF;
  localparam logic [31:0] W_BNE = 32'h7BDF_FFFF;
  // ADD(R3, R4, R5): opcode 100000, rc=5, ra=3, rb=4
  localparam logic [31:0] ADD_R3 = {6'b100000, 5'd5, 5'd3, 5'd4, 11'd0};
  // SUB(R1, R2, R7)
  localparam logic [31:0] SUB_R1 = {6'b100001, 5'd7, 5'd1, 5'd2, 11'd0};
  // BEQ(R6, offset -1, R0)
  localparam logic [31:0] BEQ_R6 = {6'b011101, 5'd0, 5'd6, 16'hFFFF};
  // ADD(R31, R31, R1)
  localparam logic [31:0] ADD_R31 = {6'b100000, 5'd1, 5'd31, 5'd31, 11'd0};

  logic clk = 1'b0;
  logic reset;
  logic stall_in;
  logic [1:0] irsrc;
  logic [XLEN-1:0] pcin, irin;
  logic [4:0] wa;
  logic [XLEN-1:0] wd;
  logic werf;
  logic [NBYP*5-1:0] byp_addr;
  logic [NBYP*XLEN-1:0] byp_data;
  logic [NBYP-1:0] byp_valid, byp_ready;
  logic [XLEN-1:0] pcout, irout, a, b, d, jt, cRelativeA;
  logic [1:0] pcsel;
  logic z, stall_out;
  logic [CNTW-1:0] stall_cnt;

  beta_rf_bypass #(.XLEN(XLEN), .NBYP(NBYP), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .irsrc(irsrc),
    .pcin(pcin), .irin(irin), .wa(wa), .wd(wd), .werf(werf),
    .byp_addr(byp_addr), .byp_data(byp_data), .byp_valid(byp_valid), .byp_ready(byp_ready),
    .pcout(pcout), .irout(irout), .a(a), .b(b), .d(d), .jt(jt), .cRelativeA(cRelativeA),
    .pcsel(pcsel), .z(z), .stall_out(stall_out), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_rf [32];
  logic [31:0] m_pc, m_ir;
  logic [15:0] m_cnt;
  // Expected combinational outputs
  logic [31:0] e_a, e_b, e_d, e_jt, e_crel;
  logic [1:0]  e_pcsel;
  logic        e_z, e_stall;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] rnd_ops [18] = '{6'h18, 6'h19, 6'h1B, 6'h1D, 6'h1E, 6'h1F, 6'h20, 6'h21,
                               6'h26, 6'h27, 6'h28, 6'h2E, 6'h2F, 6'h30, 6'h37, 6'h3F,
                               6'h00, 6'h1A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 5'd31) return 32'h0;
    if (werf && wa == r) return wd;
    return m_rf[r];
  endfunction

  // First (youngest) valid bypass source naming r supplies the value.
  task automatic operand(input logic [4:0] r, output logic [31:0] v, output logic st);
    v  = rf_read(r);
    st = 1'b0;
    if (r != 5'd31) begin
      for (int i = 0; i < NBYP; i++) begin
        if (byp_valid[i] && byp_addr[i*5 +: 5] == r) begin
          v  = byp_data[i*32 +: 32];
          st = !byp_ready[i];
          break;
        end
      end
    end
  endtask

  task automatic model_eval();
    logic [5:0]  op;
    logic [4:0]  r1, r2;
    logic [31:0] o1, o2, sxt;
    logic        s1, s2, legal;
    op = m_ir[31:26];
    r1 = (op == 6'h1F) ? 5'd31 : m_ir[20:16];
    if (op == 6'h19)                r2 = m_ir[25:21];
    else if (m_ir[31:30] == 2'b10)  r2 = m_ir[15:11];
    else                            r2 = 5'd31;
    operand(r1, o1, s1);
    operand(r2, o2, s2);
    sxt     = {{16{m_ir[15]}}, m_ir[15:0]};
    e_crel  = m_pc + sxt * 32'd4;
    e_a     = (op == 6'h1F) ? e_crel : o1;
    e_b     = (m_ir[31:30] == 2'b10) ? o2 : sxt;
    e_d     = o2;
    e_jt    = o1;
    e_z     = (o1 == 32'h0);
    e_stall = s1 | s2;
    legal   = (op inside {6'h18, 6'h19, 6'h1B, 6'h1D, 6'h1E, 6'h1F}) ||
              (op[5] && op[2:0] != 3'b111);
    if (!legal)            e_pcsel = 2'd3;
    else if (op == 6'h1B)  e_pcsel = 2'd2;
    else if (op == 6'h1D)  e_pcsel = e_z ? 2'd1 : 2'd0;
    else if (op == 6'h1E)  e_pcsel = e_z ? 2'd0 : 2'd1;
    else                   e_pcsel = 2'd0;
  endtask

  task automatic check_all(input string tag);
    #1;
    model_eval();
    chk({tag, ".pc"},    pcout,      m_pc);
    chk({tag, ".ir"},    irout,      m_ir);
    chk({tag, ".a"},     a,          e_a);
    chk({tag, ".b"},     b,          e_b);
    chk({tag, ".d"},     d,          e_d);
    chk({tag, ".jt"},    jt,         e_jt);
    chk({tag, ".crel"},  cRelativeA, e_crel);
    chk({tag, ".pcsel"}, 32'(pcsel), 32'(e_pcsel));
    chk({tag, ".z"},     32'(z),     32'(e_z));
    chk({tag, ".stall"}, 32'(stall_out), 32'(e_stall));
    chk({tag, ".cnt"},   32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic tick();
    logic [31:0] n_pc, n_ir;
    logic [15:0] n_cnt;
    logic        flush;
    model_eval();
    flush = (irsrc != 2'd0);
    n_pc = m_pc; n_ir = m_ir; n_cnt = m_cnt;
    if (reset) begin
      n_pc = 0; n_ir = W_NOP; n_cnt = 0;
    end else begin
      if (flush) begin
        n_pc = pcin;
        n_ir = (irsrc == 2'd1) ? W_BNE : W_NOP;
      end else if (!(stall_in || e_stall)) begin
        n_pc = pcin;
        n_ir = irin;
      end
      if (e_stall && !flush && m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    if (werf && wa != 5'd31) m_rf[wa] = wd;
    m_pc = n_pc; m_ir = n_ir; m_cnt = n_cnt;
    #1;
  endtask

  task automatic set_byp(input int i, input logic [4:0] ad, input logic [31:0] dt,
                         input logic v, input logic r);
    byp_addr[i*5 +: 5]   = ad;
    byp_data[i*32 +: 32] = dt;
    byp_valid[i]         = v;
    byp_ready[i]         = r;
  endtask

  function automatic logic [4:0] pick_reg();
    logic [4:0] r;
    r = 5'($urandom_range(0, 4));
    if ($urandom_range(0, 5) == 0) r = 5'd31;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = rnd_ops[$urandom_range(0, 17)];
    w[25:21] = pick_reg();
    w[20:16] = pick_reg();
    w[15:11] = pick_reg();
    return w;
  endfunction

  initial begin
    reset = 1; stall_in = 0; irsrc = 0; pcin = 0; irin = 0;
    wa = 0; wd = 0; werf = 0;
    byp_addr = 0; byp_data = 0; byp_valid = 0; byp_ready = 0;
    m_pc = 0; m_ir = W_NOP; m_cnt = 0;
    tick(); tick();
    reset = 0;
    check_all("reset");
    chk("rst_pcsel", 32'(pcsel), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_ir", irout, W_NOP);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);

    // Load every register with a known value
    stall_in = 1; werf = 1;
    for (int r = 0; r < 31; r++) begin
      wa = 5'(r); wd = $urandom;
      check_all("fill");
      tick();
    end
    werf = 0; stall_in = 0;

    // Write R3 then issue ADD R3,R4,R5
    wa = 5'd3; wd = 32'h1234_5678; werf = 1; irin = ADD_R3; pcin = 32'h40;
    check_all("wr_r3");
    tick();
    werf = 0; stall_in = 1;
    check_all("add");
    chk("add_a", a, 32'h1234_5678);
    chk("add_ir", irout, ADD_R3);

    // Youngest bypass source wins
    set_byp(0, 5'd3, 32'hAAAA, 1, 1);
    set_byp(2, 5'd3, 32'hBBBB, 1, 1);
    check_all("byp02");
    chk("byp_pri_a", a, 32'hAAAA);
    set_byp(0, 5'd0, 32'h0, 0, 0);
    check_all("byp2");
    chk("byp2_a", a, 32'hBBBB);
    set_byp(2, 5'd0, 32'h0, 0, 0);
    tick();

    // Load-use interlock
    stall_in = 0; irin = SUB_R1; pcin = 32'h44;
    set_byp(0, 5'd3, 32'hCCCC, 1, 0);
    check_all("stall");
    chk("stall_out", 32'(stall_out), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_all("stalled");
      chk("stall_ir", irout, ADD_R3);
      chk("stall_cnt", 32'(stall_cnt), 32'(k));
    end
    byp_ready[0] = 1;
    check_all("resume");
    chk("resume_stall", 32'(stall_out), 32'd0);
    chk("resume_a", a, 32'hCCCC);
    tick();
    check_all("issued");
    chk("issue_ir", irout, SUB_R1);
    chk("issue_pc", pcout, 32'h44);

    // Trap flush overrides an interlock
    irin = ADD_R3; pcin = 32'h48;
    tick();
    byp_ready[0] = 0; irsrc = 2'd1; pcin = 32'h4C;
    check_all("flush_pre");
    chk("flush_stall", 32'(stall_out), 32'd1);
    tick();
    irsrc = 0; set_byp(0, 5'd0, 32'h0, 0, 0);
    check_all("flush");
    chk("flush_ir", irout, W_BNE);
    chk("flush_pc", pcout, 32'h4C);
    chk("flush_cnt", 32'(stall_cnt), 32'd3);

    // BEQ at pc 0x100 with offset -1
    wa = 5'd6; wd = 32'h0; werf = 1; irin = BEQ_R6; pcin = 32'h100;
    check_all("wr_r6");
    tick();
    werf = 0; stall_in = 1;
    check_all("beq0");
    chk("beq_crel", cRelativeA, 32'hFC);
    chk("beq_taken", 32'(pcsel), 32'd1);
    wa = 5'd6; wd = 32'd5; werf = 1;
    check_all("beq_wt");
    chk("beq_wt_pcsel", 32'(pcsel), 32'd0);
    tick();
    werf = 0;
    check_all("beq5");
    chk("beq_nt", 32'(pcsel), 32'd0);

    // R31 is hard-wired to zero and never bypassed
    wa = 5'd31; wd = 32'hFFFF; werf = 1; stall_in = 0; irin = ADD_R31; pcin = 32'h104;
    check_all("wr_r31");
    tick();
    werf = 0; stall_in = 1;
    set_byp(0, 5'd31, 32'h1234, 1, 0);
    check_all("r31");
    chk("r31_a", a, 32'h0);
    chk("r31_b", b, 32'h0);
    chk("r31_nostall", 32'(stall_out), 32'd0);
    set_byp(0, 5'd0, 32'h0, 0, 0);
    stall_in = 0;

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      reset    = ($urandom_range(0, 49) == 0);
      stall_in = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 15))
        0:       irsrc = 2'd1;
        1:       irsrc = 2'($urandom_range(2, 3));
        default: irsrc = 2'd0;
      endcase
      pcin = $urandom;
      irin = rand_instr();
      werf = !reset && ($urandom_range(0, 1) == 1);
      wa   = pick_reg();
      wd   = $urandom;
      for (int i = 0; i < NBYP; i++) begin
        set_byp(i, pick_reg(), $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0));
      end
      check_all("rnd");
      tick();
    end

    // Reset in the middle of a stall drops the held instruction
    reset = 0; stall_in = 0; irsrc = 0; werf = 0;
    byp_valid = 0; byp_ready = 0;
    irin = ADD_R3; pcin = 32'h200;
    tick();
    set_byp(0, 5'd3, 32'h55, 1, 0);
    tick(); tick();
    check_all("pre_rst");
    reset = 1;
    tick();
    reset = 0;
    check_all("mid_rst");
    chk("mid_rst_ir", irout, W_NOP);
    chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    chk("mid_rst_stall", 32'(stall_out), 32'd0);

    // Continuous stall until the counter saturates
    set_byp(0, 5'd0, 32'h0, 0, 0);
    tick();
    check_all("sat_load");
    set_byp(0, 5'd3, 32'h55, 1, 0);
    repeat (65540) tick();
    check_all("sat");
    chk("sat_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    tick();
    check_all("sat_hold");
    chk("sat_hold_cnt", 32'(stall_cnt), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
